// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter serialising bytes on an external baud strobe.
// Define UART_TX_PARITY_EN to compile in the parity bit and PARITY state.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 in_clk,
   input  logic                 reset,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_out,
   output logic                 tx_busy
);

   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_tx_serializer: illegal DATA_BITS/STOP_BITS/PARITY_ODD");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // Where the bit after the last data (or parity) bit lands: the final stop bit is IDLE.
   localparam state_t AFTER_FIRST_STOP = (STOP_BITS == 1) ? S_IDLE : S_STOP;

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic                   tx_out_q, tx_out_d;
   logic                   tx_ready_q, tx_ready_d;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_out_d  = tx_out_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            // A tick in the accept cycle is deliberately ignored; ARM waits for the next one.
            if (tx_valid) begin
               shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
               parity_d = (^tx_data) ^ 1'(PARITY_ODD);
`endif
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (baud_tick) begin
               tx_out_d = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (baud_tick) begin
               tx_out_d  = shift_q[0];
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (bit_cnt_q < LAST_BIT) begin
                  shift_d   = shift_q >> 1;
                  tx_out_d  = shift_q[1];
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end else begin
`ifdef UART_TX_PARITY_EN
                  tx_out_d = parity_q;
                  state_d  = S_PARITY;
`else
                  tx_out_d = 1'b1;
                  state_d  = AFTER_FIRST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) begin
               tx_out_d = 1'b1;
               state_d  = AFTER_FIRST_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_tick) begin
               tx_out_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: begin
            tx_out_d = 1'b1;
            state_d  = S_IDLE;
         end
      endcase

      tx_ready_d = (state_d == S_IDLE);
   end

   // NOTE: non-blocking assignments here so every flop samples pre-edge values.
   always_ff @(posedge in_clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         tx_out_q   <= 1'b1;
         tx_ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_out_q   <= tx_out_d;
         tx_ready_q <= tx_ready_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx_out   = tx_out_q;
   assign tx_ready = tx_ready_q;
   assign tx_busy  = ~tx_ready_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: random + directed frames on a 1-stop/even and a 2-stop/odd instance,
// each checked bit by bit against a frame model computed from the byte.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

   localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic          in_clk = 1'b0;
   logic          reset;
   logic          baud_tick;
   logic [1:0]    tx_valid;
   logic [DB-1:0] tx_data [2];
   wire  [1:0]    tx_ready;
   wire  [1:0]    tx_out;
   wire  [1:0]    tx_busy;

   int bit_per = 216;
   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;
   int low_cnt [2] = '{0, 0};
   int prev_stop_cyc [2] = '{0, 0};

   always #5 in_clk = ~in_clk;

   // Instance g: STOP_BITS = g+1, PARITY_ODD = g.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      uart_tx_serializer #(.DATA_BITS(DB), .STOP_BITS(g + 1), .PARITY_ODD(g)) u_dut (
         .in_clk   (in_clk),
         .reset    (reset),
         .baud_tick(baud_tick),
         .tx_data  (tx_data[g]),
         .tx_valid (tx_valid[g]),
         .tx_ready (tx_ready[g]),
         .tx_out   (tx_out[g]),
         .tx_busy  (tx_busy[g])
      );
   end

   // Baud strobe changes on the falling edge so it is stable at every rising edge.
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge in_clk);
         cyc++;
         baud_tick = (cyc % bit_per == 0);
      end
   end

   initial begin
      forever begin
         @(negedge in_clk);
         for (int i = 0; i < 2; i++) if (!tx_out[i]) low_cnt[i]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_bit(input int idx, input logic [DB-1:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= DB) return b[k-1];
      if (PAR != 0 && k == DB + 1) return (^b) ^ (idx == 1);
      return 1'b1;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge in_clk);
      #1;
   endtask

   task automatic drv_slot();
      @(negedge in_clk);
      #1;
   endtask

   task automatic wait_tick(output int at);
      int  n = 0;
      int  lim = 4 * bit_per + 8;
      logic hit;
      do begin
         @(posedge in_clk);
         n++;
      end while (!baud_tick && n < lim);
      hit = baud_tick;
      #1;
      at = cyc;
      if (!hit) check("tick_timeout", hit, 1'b1);
   endtask

   // Caller has driven tx_valid/tx_data; waits for acceptance then checks the whole frame.
   task automatic check_frame(input int idx, input logic [DB-1:0] b, input bit hold,
                              input logic [DB-1:0] next_b, input bit chk_gap);
      int n = 1 + DB + PAR + idx + 1;
      int t;
      int guard = 0;
      logic [DB-1:0] rx = '0;
      while (!tx_ready[idx] && guard < 4 * n * bit_per + 8) begin
         drv_slot();
         guard++;
      end
      if (!tx_ready[idx]) check("accept_timeout", tx_ready[idx], 1'b1);
      @(posedge in_clk);
      #1;
      check("acc_line_high", tx_out[idx], 1'b1);
      check("acc_busy", tx_busy[idx], 1'b1);
      drv_slot();
      if (hold) tx_data[idx] = next_b;
      else begin
         tx_valid[idx] = 1'b0;
         tx_data[idx]  = DB'($urandom);
      end
      for (int k = 0; k < n; k++) begin
         wait_tick(t);
         if (k == 0 && chk_gap) check("b2b_gap", t - prev_stop_cyc[idx], (idx + 1) * bit_per);
         if (k == 1 + DB + PAR) prev_stop_cyc[idx] = t;
         check($sformatf("busy_k%0d", k), tx_busy[idx], k != n - 1);
         check($sformatf("ready_k%0d", k), tx_ready[idx], k == n - 1);
         if (k != n - 1) wait_cycles((bit_per - 1) / 2);
         check($sformatf("u%0d_bit%0d", idx, k), tx_out[idx], exp_bit(idx, b, k));
         if (k >= 1 && k <= DB) rx[k-1] = tx_out[idx];
      end
      check($sformatf("u%0d_rx_byte", idx), rx, b);
   endtask

   task automatic send(input int idx, input logic [DB-1:0] b);
      drv_slot();
      tx_valid[idx] = 1'b1;
      tx_data[idx]  = b;
      check_frame(idx, b, 1'b0, '0, 1'b0);
   endtask

   initial begin
      int t;
      int l0;
      int guard;
      logic [DB-1:0] b0, b1;
      int idx;

      reset    = 1'b1;
      tx_valid = '0;
      tx_data  = '{default: '0};
      wait_cycles(3);
      for (int i = 0; i < 2; i++) begin
         check("rst_tx_out", tx_out[i], 1'b1);
         check("rst_ready", tx_ready[i], 1'b1);
         check("rst_busy", tx_busy[i], 1'b0);
      end
      drv_slot();
      reset = 1'b0;

      // 8N1 pattern and the parity vectors (plain frames when parity is compiled out).
      send(0, 8'h55);
      send(0, 8'h03);
      send(1, 8'h03);
      send(0, 8'h07);

      // Back-to-back with tx_valid held high on both stop-bit configurations.
      for (int i = 0; i < 2; i++) begin
         drv_slot();
         tx_valid[i] = 1'b1;
         tx_data[i]  = 8'hA5;
         check_frame(i, 8'hA5, 1'b1, 8'h3C, 1'b0);
         check_frame(i, 8'h3C, 1'b0, '0, 1'b1);
      end

      // 0xFF on two stop bits: only the start bit is low.
      l0 = low_cnt[1];
      send(1, 8'hFF);
      wait_cycles(bit_per + 2);
      check("ff_low_cycles", low_cnt[1] - l0, bit_per);

      // Valid in the same cycle as a tick.
      guard = 0;
      do begin
         drv_slot();
         guard++;
      end while (!baud_tick && guard < bit_per + 4);
      b0 = DB'($urandom);
      tx_valid[0] = 1'b1;
      tx_data[0]  = b0;
      check_frame(0, b0, 1'b0, '0, 1'b0);

      // Reset in the middle of a 0x00 data phase.
      drv_slot();
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'h00;
      @(posedge in_clk);
      #1;
      drv_slot();
      tx_valid[0] = 1'b0;
      repeat (4) wait_tick(t);
      wait_cycles(bit_per / 4);
      check("mid_data_low", tx_out[0], 1'b0);
      drv_slot();
      reset = 1'b1;
      @(posedge in_clk);
      #1;
      check("midrst_tx_out", tx_out[0], 1'b1);
      check("midrst_ready", tx_ready[0], 1'b1);
      check("midrst_busy", tx_busy[0], 1'b0);
      drv_slot();
      reset = 1'b0;
      l0 = low_cnt[0];
      wait_cycles(3 * bit_per);
      check("post_rst_no_low", low_cnt[0] - l0, 0);
      send(0, 8'h81);

      // Random bytes, instances, strobe spacing (down to every cycle) and back-to-back pairs.
      for (int it = 0; it < 40; it++) begin
         idx = int'($urandom_range(0, 1));
         b0  = DB'($urandom);
         b1  = DB'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            bit_per = int'($urandom_range(2, 9));
            drv_slot();
            tx_valid[idx] = 1'b1;
            tx_data[idx]  = b0;
            check_frame(idx, b0, 1'b1, b1, 1'b0);
            check_frame(idx, b1, 1'b0, '0, 1'b1);
         end else begin
            bit_per = int'($urandom_range(1, 9));
            send(idx, b0);
         end
      end

      wait_cycles(2 * bit_per + 4);
      for (int i = 0; i < 2; i++) begin
         check("end_idle_line", tx_out[i], 1'b1);
         check("end_idle_ready", tx_ready[i], 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
